lfsr_bist_engine: RTL and testbench

LFSR_BIST_ENGINE -- requirements
Module: lfsr_bist_engine

---
 rtl/bist_pkg.sv | 18 +
 rtl/misr_core.sv | 38 +++
 rtl/lfsr_bist_engine.sv | 123 ++++++++++++
 tb/tb_lfsr_bist_engine.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared FSM state encoding and default polynomial/seed constants for the LFSR BIST engine.
// Pure definitions: no latency, no flow control.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_COMPARE,
    ST_DONE
  } bist_state_e;

  localparam logic [7:0] DEF_LFSR_TAPS  = 8'hB8;
  localparam logic [7:0] DEF_LFSR_SEED  = 8'h01;
  localparam logic [3:0] DEF_MISR_TAPS  = 4'h9;
  localparam logic [3:0] DEF_GOLDEN_SIG = 4'hF;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: folds one response word per enabled cycle.
// Signature updates on the edge after en; clr wins over en; no backpressure.
module misr_core
  import bist_pkg::*;
#(
  parameter int                MISR_W    = 4,
  parameter logic [MISR_W-1:0] MISR_TAPS = DEF_MISR_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [MISR_W-1:0] din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] misr_q, misr_d;

  always_comb begin
    misr_d = misr_q;
    if (clr) begin
      misr_d = '0;
    end else if (en) begin
      misr_d = {misr_q[MISR_W-2:0], ^(misr_q & MISR_TAPS)} ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misr_q <= '0;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign sig = misr_q;

endmodule

// File: rtl/lfsr_bist_engine.sv
// LFSR pattern generator + MISR compactor BIST controller; done TEST_LEN+3 edges after start.
// No backpressure (start ignored while busy, abort always wins); BIST_STUCK_INJECT_EN adds stuck-at-0 response masking.
module lfsr_bist_engine
  import bist_pkg::*;
#(
  parameter int                LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = DEF_LFSR_TAPS,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = DEF_LFSR_SEED,
  parameter int                MISR_W     = 4,
  parameter logic [MISR_W-1:0] MISR_TAPS  = DEF_MISR_TAPS,
  parameter int                TEST_LEN   = 16,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = DEF_GOLDEN_SIG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [LFSR_W-1:0] pattern,
  output logic              pattern_valid,
  input  logic [MISR_W-1:0] resp,
`ifdef BIST_STUCK_INJECT_EN
  input  logic              inj_en,
  input  logic [MISR_W-1:0] inj_mask,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass_fail,
  output logic [MISR_W-1:0] signature
);

  localparam int                CNT_W    = $clog2(TEST_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TEST_LEN - 1);
  // All-zero is the LFSR lock-up state, so it is never used as a seed.
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  bist_state_e       state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic              misr_clr, misr_en;
  logic [MISR_W-1:0] resp_eff;
  logic [MISR_W-1:0] misr_sig;

`ifdef BIST_STUCK_INJECT_EN
  assign resp_eff = inj_en ? (resp & ~inj_mask) : resp;
`else
  assign resp_eff = resp;
`endif

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_SEED;
        end
        ST_SEED: begin
          lfsr_d   = SEED_EFF;
          cnt_d    = '0;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          lfsr_d  = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
          misr_en = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = ST_COMPARE;
        end
        ST_COMPARE: begin
          pass_d  = (misr_sig == GOLDEN_SIG);
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (start) state_d = ST_SEED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED_EFF;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  misr_core #(
    .MISR_W   (MISR_W),
    .MISR_TAPS(MISR_TAPS)
  ) u_misr (
    .clk(clk),
    .rst(rst),
    .clr(misr_clr),
    .en (misr_en),
    .din(resp_eff),
    .sig(misr_sig)
  );

  assign pattern       = lfsr_q;
  assign pattern_valid = (state_q == ST_RUN);
  assign busy          = (state_q == ST_SEED) || (state_q == ST_RUN) || (state_q == ST_COMPARE);
  assign done          = (state_q == ST_DONE);
  assign pass_fail     = pass_q;
  assign signature     = misr_sig;

endmodule

// File: tb/tb_lfsr_bist_engine.sv
// Directed bench for lfsr_bist_engine: per-edge vector table for one full run plus abort/reset/short-run sequences.
module tb_lfsr_bist_engine;

  // Reference signature: taps written out as explicit bit XORs.
  function automatic logic [3:0] model_sig(input int len, input logic [7:0] seed, input logic zero_in);
    logic [7:0] p;
    logic [3:0] m;
    logic [3:0] r;
    p = (seed == 8'h00) ? 8'h01 : seed;
    m = 4'h0;
    for (int i = 0; i < len; i++) begin
      r = zero_in ? 4'h0 : (p[3:0] ^ p[7:4]);
      m = {m[2:0], m[3] ^ m[0]} ^ r;
      p = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    end
    return m;
  endfunction

  localparam logic [3:0] MODEL_SIG  = model_sig(16, 8'h01, 1'b0);
  localparam logic [3:0] MODEL_ZERO = model_sig(16, 8'h01, 1'b1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort;

  logic [7:0] pat_a, pat_b, pat_s;
  logic [3:0] resp_a, resp_b, resp_s;
  logic       pv_a, busy_a, done_a, pf_a;
  logic       pv_b, busy_b, done_b, pf_b;
  logic       pv_s, busy_s, done_s, pf_s;
  logic [3:0] sig_a, sig_b, sig_s;

  assign resp_a = pat_a[3:0] ^ pat_a[7:4];
  assign resp_b = pat_b[3:0] ^ pat_b[7:4];
  assign resp_s = pat_s[3:0] ^ pat_s[7:4];

  lfsr_bist_engine #(.GOLDEN_SIG(MODEL_SIG)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pat_a), .pattern_valid(pv_a), .resp(resp_a),
`ifdef BIST_STUCK_INJECT_EN
    .inj_en(1'b0), .inj_mask(4'h0),
`endif
    .busy(busy_a), .done(done_a), .pass_fail(pf_a), .signature(sig_a)
  );

  lfsr_bist_engine #(.GOLDEN_SIG(MODEL_SIG ^ 4'h1)) u_bad (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pat_b), .pattern_valid(pv_b), .resp(resp_b),
`ifdef BIST_STUCK_INJECT_EN
    .inj_en(1'b0), .inj_mask(4'h0),
`endif
    .busy(busy_b), .done(done_b), .pass_fail(pf_b), .signature(sig_b)
  );

  lfsr_bist_engine #(.TEST_LEN(1), .LFSR_SEED(8'h00)) u_short (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pat_s), .pattern_valid(pv_s), .resp(resp_s),
`ifdef BIST_STUCK_INJECT_EN
    .inj_en(1'b0), .inj_mask(4'h0),
`endif
    .busy(busy_s), .done(done_s), .pass_fail(pf_s), .signature(sig_s)
  );

`ifdef BIST_STUCK_INJECT_EN
  logic [7:0] pat_i;
  logic [3:0] resp_i, sig_i;
  logic       pv_i, busy_i, done_i, pf_i;
  assign resp_i = pat_i[3:0] ^ pat_i[7:4];
  lfsr_bist_engine #(.GOLDEN_SIG(MODEL_SIG)) u_inj (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pat_i), .pattern_valid(pv_i), .resp(resp_i),
    .inj_en(1'b1), .inj_mask(4'hF),
    .busy(busy_i), .done(done_i), .pass_fail(pf_i), .signature(sig_i)
  );
`endif

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for the first edge, then counts edges until done (bounded).
  task automatic run_to_done(output int n);
    n = 0;
    start = 1'b1;
    while (!done_a && n < 60) begin
      tick();
      n++;
      start = 1'b0;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       busy;
    logic       pv;
    logic       done;
    logic [7:0] pat;
    logic       s_done;
  } vec_t;

  vec_t       tv[19];
  logic [7:0] exp_pat[16];
  int         n_edges;

  initial begin
    exp_pat = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E,
                8'h1C, 8'h38, 8'h71, 8'hE2, 8'hC4, 8'h89, 8'h12, 8'h25};
    // Row k holds inputs for edge k+1 and the outputs expected just after it.
    // The second start pulse lands in RUN and must be ignored.
    for (int k = 0; k < 19; k++) begin
      tv[k].start  = (k == 0) || (k == 2);
      tv[k].busy   = (k <= 17);
      tv[k].pv     = (k >= 1) && (k <= 16);
      tv[k].done   = (k == 18);
      tv[k].pat    = tv[k].pv ? exp_pat[k-1] : 8'h00;
      tv[k].s_done = (k >= 3);
    end

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pv", 32'(pv_a), 32'd0);
    check("rst_pf", 32'(pf_a), 32'd0);
    check("rst_sig", 32'(sig_a), 32'h0);
    check("rst_pat", 32'(pat_a), 32'h01);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 19; k++) begin
      start = tv[k].start;
      tick();
      check($sformatf("busy@%0d", k + 1), 32'(busy_a), 32'(tv[k].busy));
      check($sformatf("pv@%0d", k + 1), 32'(pv_a), 32'(tv[k].pv));
      check($sformatf("done@%0d", k + 1), 32'(done_a), 32'(tv[k].done));
      if (tv[k].pv) check($sformatf("pat@%0d", k + 1), 32'(pat_a), 32'(tv[k].pat));
      check($sformatf("short_done@%0d", k + 1), 32'(done_s), 32'(tv[k].s_done));
      if (k == 1) begin
        check("short_pat", 32'(pat_s), 32'h01);
        check("short_pv", 32'(pv_s), 32'd1);
      end
    end
    start = 1'b0;
    check("pass_a", 32'(pf_a), 32'd1);
    check("sig_a_model", 32'(sig_a), 32'(MODEL_SIG));
    check("sig_a_hand", 32'(sig_a), 32'h5);
    check("bad_done", 32'(done_b), 32'd1);
    check("bad_pass", 32'(pf_b), 32'd0);
    check("bad_sig", 32'(sig_b), 32'(MODEL_SIG));
    check("short_sig", 32'(sig_s), 32'(model_sig(1, 8'h00, 1'b0)));
`ifdef BIST_STUCK_INJECT_EN
    check("inj_done", 32'(done_i), 32'd1);
    check("inj_sig", 32'(sig_i), 32'(MODEL_ZERO));
    check("inj_pass", 32'(pf_i), 32'(MODEL_ZERO == MODEL_SIG));
`endif
    tick();
    check("done_hold", 32'(done_a), 32'd1);
    check("pass_hold", 32'(pf_a), 32'd1);

    // Restart from DONE, abort in RUN cycle 5 with start also high.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("abort_pre_pat", 32'(pat_a), 32'h11);
    check("abort_pre_pv", 32'(pv_a), 32'd1);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_pf", 32'(pf_a), 32'd0);
    check("abort_pv", 32'(pv_a), 32'd0);
    tick();
    check("abort_idle", 32'(busy_a), 32'd0);

    run_to_done(n_edges);
    check("rerun_done_edge", 32'(n_edges), 32'd19);
    check("rerun_sig", 32'(sig_a), 32'(MODEL_SIG));
    check("rerun_pass", 32'(pf_a), 32'd1);

    // Reset in the middle of RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("mid_pv", 32'(pv_a), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    check("midrst_pv", 32'(pv_a), 32'd0);
    check("midrst_pf", 32'(pf_a), 32'd0);
    check("midrst_sig", 32'(sig_a), 32'h0);
    check("midrst_pat", 32'(pat_a), 32'h01);
    tick();
    check("midrst_stay_idle", 32'(busy_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
